fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle RV64 core.
- Issues in-order 32-bit instruction reads to the instruction memory port and buffers returned words with their PCs in a small FIFO.
- Presents one instruction per cycle to decode with a valid/ready handshake.
- Flushes and redirects on the core's jump signal; discards stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (1..DEPTH).
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- JumpEn  input  1  redirect pulse from jump logic, one cycle.
- JumpAddr  input  64  redirect target; bits [1:0] ignored and forced to 0.
- MemReqValid  output  1  fetch request valid.
- MemReqAddr  output  64  fetch address, word aligned.
- MemReqReady  input  1  memory accepts the request this cycle.
- MemRespValid  input  1  read data valid; responses in request order, at most one per cycle, never earlier than the cycle after acceptance.
- MemRespData  input  32  returned instruction word.
- InstValid  output  1  FIFO head valid.
- Instruction  output  32  head instruction word.
- InstructionAddr  output  64  head instruction PC.
- InstReady  input  1  decode consumes the head this cycle.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - fetch_pc = resp_pc = RESET_PC.
  - count = outstanding = drop = 0.
  - Outputs: MemReqValid=0, InstValid=0, Instruction=0, InstructionAddr=0, MemReqAddr=RESET_PC.
  - Reset mid-transfer abandons all in-flight requests; the memory side must also be reset.
- Request issue:
  - MemReqValid = (count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING) && !JumpEn.
  - MemReqAddr = fetch_pc.
  - Accept = MemReqValid && MemReqReady; on accept, fetch_pc += 4 (mod 2^64, no wrap trap) and outstanding += 1.
  - Addr is held stable while unaccepted, except on redirect.
- Response:
  - Every response is accepted; space was reserved at request time.
  - If drop > 0: discard the word, drop -= 1.
  - Otherwise: push {resp_pc, MemRespData}, then resp_pc += 4.
  - outstanding -= 1 either way. Accept and response in the same cycle leaves outstanding unchanged.
- Output:
  - InstValid = (count != 0); head data is registered FIFO storage.
  - Pop when InstValid && InstReady.
  - Push and pop in the same cycle leaves count unchanged; count never exceeds DEPTH, and the bench asserts this.
- Redirect (JumpEn=1) has highest priority:
  - FIFO cleared (count=0, pointers reset); any push/pop in this cycle is ignored.
  - fetch_pc = resp_pc = {JumpAddr[63:2],2'b00}.
  - drop = outstanding + accept - MemRespValid, where accept is forced to 0 because MemReqValid=0 during JumpEn.
  - InstValid=0 in the next cycle; the first new request is issued in the next cycle.
  - Back-to-back JumpEn is legal; each recomputes drop and the last target wins.
- Latency:
  - With MemReqReady=1 and a 1-cycle response, the first request is at cycle 0 after reset release, the response at cycle 1, and InstValid at cycle 2.
  - Steady state is 1 instruction/cycle when MAX_OUTSTANDING ≥ 2 and InstReady=1.
- Stall: InstReady=0 holds the head stable; issue stops once count + outstanding = DEPTH.

Optional Feature:
- Macro FETCH_QUEUE_STAT_EN.
- When defined, adds output ports StarveCycles[31:0] and DroppedResps[31:0], both reset to 0:
  - StarveCycles increments on every cycle with InstValid=0 && !JumpEn.
  - DroppedResps increments on each discarded response.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, MemReqReady=1, 1-cycle memory returning 32'h00000013 → MemReqAddr 0x80000000, 0x80000004, …; InstValid at cycle 2 with InstructionAddr=0x80000000, then one instruction per cycle.
- InstReady=0 held for 10 cycles → exactly DEPTH=4 words buffered, MemReqValid=0, count never 5; release yields PCs 0x80000000..0x8000000C in order with no gaps.
- JumpEn with JumpAddr=0x80001003 while 2 requests are outstanding → both stale responses discarded; next InstructionAddr=0x80001000; FIFO empty the cycle after JumpEn.
- JumpEn coincident with a MemRespValid and an InstReady pop → response dropped, pop ignored, drop = outstanding-1.
- MemReqReady toggling 1010… with 3-cycle response latency → MemReqAddr stable while unaccepted, outstanding ≤ 2, in-order PCs delivered.
- fetch_pc at 0xFFFFFFFFFFFFFFFC → next request address 0x0, no error (with FETCH_QUEUE_STAT_EN, StarveCycles counts the initial 2 empty cycles).

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order 32-bit reads, buffers {pc, word} in a FIFO for decode.
// Optional statistics counters StarveCycles/DroppedResps are enabled by defining FETCH_QUEUE_STAT_EN.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        JumpEn,
  input  logic [63:0] JumpAddr,
  output logic        MemReqValid,
  output logic [63:0] MemReqAddr,
  input  logic        MemReqReady,
  input  logic        MemRespValid,
  input  logic [31:0] MemRespData,
  output logic        InstValid,
  output logic [31:0] Instruction,
  output logic [63:0] InstructionAddr,
  input  logic        InstReady
`ifdef FETCH_QUEUE_STAT_EN
  ,
  output logic [31:0] StarveCycles,
  output logic [31:0] DroppedResps
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = CW + 1;

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [63:0]   fifo_pc   [DEPTH];

  logic [SW-1:0] used_slots;
  logic [63:0]   jump_target;
  logic          accept;
  logic          push;
  logic          pop;
  logic          drop_resp;

  // A slot is reserved for every outstanding request so responses can always be absorbed.
  assign used_slots  = SW'(count) + SW'(outstanding);
  assign jump_target = JumpAddr & ~64'h3;

  assign MemReqValid = rst_n && (used_slots < SW'(DEPTH)) &&
                       (outstanding < OW'(MAX_OUTSTANDING)) && !JumpEn;
  assign MemReqAddr  = fetch_pc;
  assign accept      = MemReqValid && MemReqReady;
  assign drop_resp   = MemRespValid && (drop != '0);
  assign push        = MemRespValid && (drop == '0) && !JumpEn;
  assign InstValid   = (count != '0);
  assign pop         = InstValid && InstReady && !JumpEn;

  // Storage itself is not reset, so the head is masked to zero while empty.
  assign Instruction     = InstValid ? fifo_inst[rd_ptr] : '0;
  assign InstructionAddr = InstValid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (JumpEn) begin
      // Every request still in flight now belongs to the old path.
      fetch_pc    <= jump_target;
      resp_pc     <= jump_target;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= outstanding - OW'(MemRespValid);
      drop        <= outstanding - OW'(MemRespValid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 64'd4;
      if (push) begin
        resp_pc <= resp_pc + 64'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      if (drop_resp) drop   <= drop - OW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + OW'(accept) - OW'(MemRespValid);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= MemRespData;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_QUEUE_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StarveCycles <= '0;
      DroppedResps <= '0;
    end else begin
      if (!InstValid && !JumpEn) StarveCycles <= sat_inc(StarveCycles);
      // Responses arriving with the redirect are discarded as well.
      if (MemRespValid && (drop != '0 || JumpEn)) DroppedResps <= sat_inc(DroppedResps);
    end
  end
`endif

endmodule
